// File: rtl/fpu_sram_sequencer.sv
// fpu_sram_sequencer: reads two SRAM operands, runs the FPU, writes the result back and pulses a response
module fpu_sram_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_d,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [4:0]            resp_flags,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic                  fpu_start,
  output logic [1:0]            fpu_op,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  input  logic [4:0]            fpu_flags,
  input  logic                  fpu_done
);
  typedef enum logic [2:0] {IDLE, RD, CAP, EXEC, WR, RESP} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic is_move, done_ok, timeout;
  assign cmd_ready = state == IDLE && !rst;
  assign is_move   = fpu_op == 2'd3;
  // the done strobe in the launch cycle belongs to nothing we started
  assign done_ok   = fpu_done && cnt != CNT_WIDTH'(1);
  assign timeout   = cnt == CNT_WIDTH'(TIMEOUT);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_valid ? RD : IDLE;
      RD:      state_n = CAP;
      CAP:     state_n = is_move ? WR : EXEC;
      EXEC:    state_n = done_ok ? WR : timeout ? RESP : EXEC;
      WR:      state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // pins are registered from the next state so the SRAM sees them for the whole cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= 1'b1;
      sram_addr1  <= '0;
      fpu_start   <= 1'b0;
      fpu_op      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_flags  <= '0;
      cnt         <= '0;
      addr_d      <= '0;
    end else begin
      sram_csb0   <= !(state_n == RD || state_n == WR);
      sram_web0   <= state_n != WR;
      sram_wmask0 <= state_n == WR ? '1 : '0;
      sram_csb1   <= state_n != RD;
      fpu_start   <= state == CAP && state_n == EXEC;
      resp_valid  <= state_n == RESP;
      if (state == IDLE && cmd_valid) begin
        fpu_op     <= cmd_op;
        sram_addr0 <= cmd_addr_a;
        sram_addr1 <= cmd_addr_b;
        addr_d     <= cmd_addr_d;
        resp_err   <= 1'b0;
        resp_flags <= '0;
      end
      if (state == CAP) begin
        fpu_a <= sram_dout0;
        fpu_b <= sram_dout1;
      end
      if (state_n == EXEC)
        cnt <= state == EXEC ? cnt + 1'b1 : CNT_WIDTH'(1);
      if (state_n == WR) begin
        sram_addr0 <= addr_d;
        sram_din0  <= state == CAP ? sram_dout0 : fpu_result;
      end
      if (state == EXEC && done_ok)
        resp_flags <= fpu_flags;
      if (state == EXEC && state_n == RESP)
        resp_err <= 1'b1;
    end
  end
endmodule
